// File: rtl/if_ctrl_pkg.sv
// Shared pipeline constants for the IF, ID and EX stages: FSM encodings,
// default reset PC, the NOP bubble word and the pending-redirect record.
package if_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_BUBBLE   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } if_state_e;

    // Redirect held while instruction memory is busy
    typedef struct packed {
        logic            valid;
        logic            is_cond;
        logic [XLEN-1:0] target;
    } redirect_t;

endpackage

// File: rtl/if_ctrl_sat_counter.sv
// Saturating up-counter used for stall statistics.
// Ports: clk, rst (async active-high clear), inc (count enable), count.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Stops at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/if_ctrl.sv
// Instruction-fetch control: next-PC selection, pipeline stall/flush
// control and instruction-memory wait handling with a pending redirect.
// Ports: clk, rst; hazard/redirect inputs cond/condNPC, jmp/jmpPC, loadUse,
// memBusy, seqPC; outputs NPC, pcWrite, ifidWrite, ifidFlush, idexFlush
// (combinational), state and stallCnt (registered).
module if_ctrl
    import if_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] BUBBLE   = DEF_BUBBLE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cond,
    input  logic [31:0] condNPC,
    input  logic        jmp,
    input  logic [31:0] jmpPC,
    input  logic        loadUse,
    input  logic        memBusy,
    input  logic [31:0] seqPC,
    output logic [31:0] NPC,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic [1:0]  state,
    output logic [15:0] stallCnt
);

    if_state_e state_q, state_d;
    redirect_t pend_q, pend_d;

    logic [XLEN-1:0] sel_npc;
    logic            sel_stall;
    logic            sel_ifid_fl;
    logic            sel_idex_fl;

    // BUBBLE is consumed by the IF/ID and ID/EX registers, not here
    logic unused_bubble;
    assign unused_bubble = ^BUBBLE;

    // State and pending-redirect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pend_q  <= '{valid: 1'b0, is_cond: 1'b0, target: RESET_PC};
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Hazard priority shared by RUN and WAIT: cond > loadUse > jmp > seq
    always_comb begin
        sel_npc     = seqPC;
        sel_stall   = 1'b0;
        sel_ifid_fl = 1'b0;
        sel_idex_fl = 1'b0;
        if (cond) begin
            sel_npc     = condNPC;
            sel_ifid_fl = 1'b1;
            sel_idex_fl = 1'b1;
        end else if (loadUse) begin
            sel_stall   = 1'b1;
            sel_idex_fl = 1'b1;
        end else if (jmp) begin
            sel_npc     = jmpPC;
            sel_ifid_fl = 1'b1;
        end
    end

    // Next state, pending update and control outputs
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        NPC       = seqPC;
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;

        case (state_q)
            ST_BOOT: begin
                NPC       = RESET_PC;
                ifidFlush = 1'b1;
                idexFlush = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                NPC       = sel_npc;
                pcWrite   = ~sel_stall;
                ifidWrite = ~sel_stall;
                ifidFlush = sel_ifid_fl;
                idexFlush = sel_idex_fl;
                if (memBusy) begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    state_d   = ST_WAIT;
                    if (cond) begin
                        pend_d = '{valid: 1'b1, is_cond: 1'b1, target: condNPC};
                    end else if (jmp && !loadUse) begin
                        pend_d = '{valid: 1'b1, is_cond: 1'b0, target: jmpPC};
                    end
                end
            end
            ST_WAIT: begin
                NPC       = sel_npc;
                ifidFlush = sel_ifid_fl;
                idexFlush = sel_idex_fl;
                if (memBusy) begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    // A jump never displaces a pending branch target
                    if (cond) begin
                        pend_d = '{valid: 1'b1, is_cond: 1'b1, target: condNPC};
                    end else if (jmp && !loadUse && !(pend_q.valid && pend_q.is_cond)) begin
                        pend_d = '{valid: 1'b1, is_cond: 1'b0, target: jmpPC};
                    end
                end else begin
                    state_d      = ST_RUN;
                    pend_d.valid = 1'b0;
                    if (pend_q.valid && !cond) begin
                        NPC       = pend_q.target;
                        ifidFlush = 1'b1;
                        idexFlush = 1'b0;
                    end else begin
                        pcWrite   = ~sel_stall;
                        ifidWrite = ~sel_stall;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Reset holds both pipeline slots as bubbles and freezes the PC
        if (rst) begin
            NPC       = RESET_PC;
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end
    end

    assign state = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~pcWrite && (state_q != ST_BOOT)),
        .count (stallCnt)
    );

endmodule

// File: tb/tb_if_ctrl.sv
// Directed self-checking bench for if_ctrl.
module tb_if_ctrl;

    logic        clk;
    logic        rst;
    logic        cond;
    logic [31:0] condNPC;
    logic        jmp;
    logic [31:0] jmpPC;
    logic        loadUse;
    logic        memBusy;
    logic [31:0] seqPC;
    logic [31:0] NPC;
    logic        pcWrite;
    logic        ifidWrite;
    logic        ifidFlush;
    logic        idexFlush;
    logic [1:0]  state;
    logic [15:0] stallCnt;

    int checks;
    int failures;

    if_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cond      (cond),
        .condNPC   (condNPC),
        .jmp       (jmp),
        .jmpPC     (jmpPC),
        .loadUse   (loadUse),
        .memBusy   (memBusy),
        .seqPC     (seqPC),
        .NPC       (NPC),
        .pcWrite   (pcWrite),
        .ifidWrite (ifidWrite),
        .ifidFlush (ifidFlush),
        .idexFlush (idexFlush),
        .state     (state),
        .stallCnt  (stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks run 4 units later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic set_idle();
        cond    = 1'b0;
        condNPC = 32'h0;
        jmp     = 1'b0;
        jmpPC   = 32'h0;
        loadUse = 1'b0;
        memBusy = 1'b0;
        seqPC   = 32'h4;
    endtask

    // Reset, then step through BOOT into RUN
    task automatic go_run();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        tick();
        settle();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (NPC !== 32'h0) begin failures++; $display("FAIL rst_npc got=%h exp=%h", NPC, 32'h0); end
        checks++; if ({pcWrite, ifidWrite, ifidFlush, idexFlush} !== 4'b0011) begin
            failures++; $display("FAIL rst_ctrl got=%b exp=0011", {pcWrite, ifidWrite, ifidFlush, idexFlush}); end
        checks++; if (stallCnt !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%h exp=0000", stallCnt); end
        tick();
        rst = 1'b0;
        settle();
        checks++; if (state !== 2'd0 || NPC !== 32'h0 || pcWrite !== 1'b1 || ifidFlush !== 1'b1 || idexFlush !== 1'b1) begin
            failures++; $display("FAIL boot got st=%0d npc=%h pw=%b ff=%b%b exp st=0 npc=0 pw=1 ff=11",
                                 state, NPC, pcWrite, ifidFlush, idexFlush); end
        tick();
        settle();
        checks++; if (state !== 2'd1 || NPC !== 32'h4 || pcWrite !== 1'b1 || ifidWrite !== 1'b1
                      || ifidFlush !== 1'b0 || idexFlush !== 1'b0) begin
            failures++; $display("FAIL run_first got st=%0d npc=%h pw=%b iw=%b ff=%b%b exp st=1 npc=4 pw=1 iw=1 ff=00",
                                 state, NPC, pcWrite, ifidWrite, ifidFlush, idexFlush); end
        checks++; if (stallCnt !== 16'h0) begin failures++; $display("FAIL boot_cnt got=%h exp=0000", stallCnt); end
    endtask

    task automatic test_priority();
        go_run();
        cond = 1'b1; condNPC = 32'h40; jmp = 1'b1; jmpPC = 32'h80;
        settle();
        checks++; if (NPC !== 32'h40 || ifidFlush !== 1'b1 || idexFlush !== 1'b1 || pcWrite !== 1'b1) begin
            failures++; $display("FAIL cond_prio got npc=%h ff=%b%b pw=%b exp npc=40 ff=11 pw=1",
                                 NPC, ifidFlush, idexFlush, pcWrite); end
        tick();
        cond = 1'b0;
        settle();
        checks++; if (NPC !== 32'h80 || ifidFlush !== 1'b1 || idexFlush !== 1'b0) begin
            failures++; $display("FAIL jmp_only got npc=%h ff=%b%b exp npc=80 ff=10", NPC, ifidFlush, idexFlush); end
        tick();
        cond = 1'b1; condNPC = 32'hDEAD_BEEF; jmp = 1'b0; loadUse = 1'b1;
        settle();
        checks++; if (NPC !== 32'hDEAD_BEEF || pcWrite !== 1'b1 || ifidFlush !== 1'b1 || idexFlush !== 1'b1) begin
            failures++; $display("FAIL cond_over_lu got npc=%h pw=%b ff=%b%b exp npc=deadbeef pw=1 ff=11",
                                 NPC, pcWrite, ifidFlush, idexFlush); end
        tick();
        set_idle();
        settle();
        checks++; if (stallCnt !== 16'h0) begin failures++; $display("FAIL prio_cnt got=%h exp=0000", stallCnt); end
    endtask

    task automatic test_load_use();
        go_run();
        loadUse = 1'b1; jmp = 1'b1; jmpPC = 32'h80;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (pcWrite !== 1'b0 || ifidWrite !== 1'b0 || idexFlush !== 1'b1 || ifidFlush !== 1'b0 || NPC === 32'h80) begin
                failures++; $display("FAIL lu_stall%0d got pw=%b iw=%b ff=%b%b npc=%h exp pw=0 iw=0 ff=01 npc!=80",
                                     i, pcWrite, ifidWrite, ifidFlush, idexFlush, NPC); end
            tick();
        end
        loadUse = 1'b0;
        settle();
        checks++; if (stallCnt !== 16'd2) begin failures++; $display("FAIL lu_cnt got=%0d exp=2", stallCnt); end
        checks++; if (NPC !== 32'h80 || ifidFlush !== 1'b1 || pcWrite !== 1'b1) begin
            failures++; $display("FAIL lu_rejmp got npc=%h ff=%b pw=%b exp npc=80 ff=1 pw=1", NPC, ifidFlush, pcWrite); end
        tick();
        set_idle();
    endtask

    task automatic test_mem_busy();
        go_run();
        memBusy = 1'b1; cond = 1'b1; condNPC = 32'h100;
        settle();
        checks++; if (pcWrite !== 1'b0 || ifidWrite !== 1'b0 || ifidFlush !== 1'b1 || idexFlush !== 1'b1) begin
            failures++; $display("FAIL mb_first got pw=%b iw=%b ff=%b%b exp pw=0 iw=0 ff=11",
                                 pcWrite, ifidWrite, ifidFlush, idexFlush); end
        tick();
        cond = 1'b0; condNPC = 32'h0;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (state !== 2'd2 || pcWrite !== 1'b0) begin
                failures++; $display("FAIL mb_wait%0d got st=%0d pw=%b exp st=2 pw=0", i, state, pcWrite); end
            tick();
        end
        memBusy = 1'b0;
        settle();
        checks++; if (state !== 2'd2 || NPC !== 32'h100 || ifidFlush !== 1'b1 || pcWrite !== 1'b1) begin
            failures++; $display("FAIL mb_release got st=%0d npc=%h ff=%b pw=%b exp st=2 npc=100 ff=1 pw=1",
                                 state, NPC, ifidFlush, pcWrite); end
        tick();
        settle();
        checks++; if (state !== 2'd1 || NPC !== 32'h4 || ifidFlush !== 1'b0) begin
            failures++; $display("FAIL mb_after got st=%0d npc=%h ff=%b exp st=1 npc=4 ff=0", state, NPC, ifidFlush); end
        checks++; if (stallCnt !== 16'd3) begin failures++; $display("FAIL mb_cnt got=%0d exp=3", stallCnt); end
    endtask

    task automatic test_pending_override();
        go_run();
        // Pending cond survives a later jmp
        memBusy = 1'b1; cond = 1'b1; condNPC = 32'h100;
        tick();
        cond = 1'b0; jmp = 1'b1; jmpPC = 32'h200;
        tick();
        jmp = 1'b0; memBusy = 1'b0;
        settle();
        checks++; if (NPC !== 32'h100) begin failures++; $display("FAIL pend_keep got=%h exp=%h", NPC, 32'h100); end
        tick();
        // A later cond replaces the pending target
        memBusy = 1'b1; cond = 1'b1; condNPC = 32'h100;
        tick();
        cond = 1'b0; jmp = 1'b1; jmpPC = 32'h200;
        tick();
        jmp = 1'b0; cond = 1'b1; condNPC = 32'h300;
        tick();
        cond = 1'b0; condNPC = 32'h0; memBusy = 1'b0;
        settle();
        checks++; if (NPC !== 32'h300 || ifidFlush !== 1'b1) begin
            failures++; $display("FAIL pend_replace got npc=%h ff=%b exp npc=300 ff=1", NPC, ifidFlush); end
        tick();
        set_idle();
    endtask

    task automatic test_saturation();
        go_run();
        memBusy = 1'b1;
        repeat (65534) tick();
        settle();
        checks++; if (stallCnt !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", stallCnt); end
        tick();
        settle();
        checks++; if (stallCnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hit got=%h exp=ffff", stallCnt); end
        cond = 1'b1; condNPC = 32'h300;
        repeat (3) tick();
        cond = 1'b0;
        settle();
        checks++; if (stallCnt !== 16'hFFFF || state !== 2'd2) begin
            failures++; $display("FAIL sat_hold got cnt=%h st=%0d exp cnt=ffff st=2", stallCnt, state); end
        tick();
        // Asynchronous reset mid-WAIT with a pending redirect
        rst = 1'b1;
        #1;
        checks++; if (state !== 2'd0 || stallCnt !== 16'h0) begin
            failures++; $display("FAIL async_rst got st=%0d cnt=%h exp st=0 cnt=0000", state, stallCnt); end
        set_idle();
        tick();
        tick();
        rst = 1'b0;
        tick();
        settle();
        checks++; if (state !== 2'd1 || NPC !== 32'h4 || ifidFlush !== 1'b0) begin
            failures++; $display("FAIL rst_pend_clr got st=%0d npc=%h ff=%b exp st=1 npc=4 ff=0", state, NPC, ifidFlush); end
        memBusy = 1'b1;
        tick();
        memBusy = 1'b0;
        settle();
        checks++; if (NPC !== 32'h4 || ifidFlush !== 1'b0) begin
            failures++; $display("FAIL rst_pend_rel got npc=%h ff=%b exp npc=4 ff=0", NPC, ifidFlush); end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set_idle();
        test_reset();
        test_priority();
        test_load_use();
        test_mem_busy();
        test_pending_override();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_ctrl.md
IF_CTRL -- requirements
Module: if_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUBBLE, default 32'hFFFF_FFFF, meaning the instruction word that marks an IF/ID or ID/EX slot as a NOP.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports named as below.
REQ-004 SHALL have the following ports (clock and reset first):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- cond  in  1  EX-stage branch taken
- condNPC  in  32  EX branch target
- jmp  in  1  ID-stage J-type jump decoded
- jmpPC  in  32  ID jump target
- loadUse  in  1  ID load-use hazard
- memBusy  in  1  instruction memory not ready this cycle
- seqPC  in  32  sequential next PC (PC+4) from fetch
- NPC  out  32  selected next PC
- pcWrite  out  1  PC register update enable
- ifidWrite  out  1  IF/ID register update enable
- ifidFlush  out  1  load BUBBLE into IF/ID
- idexFlush  out  1  load BUBBLE into ID/EX
- state  out  2  FSM state
- stallCnt  out  16  saturating count of stalled cycles

Function
REQ-005 SHALL implement FSM states BOOT=0, RUN=1, WAIT=2; encoding 3 is unused and SHALL go to RUN.
REQ-006 BOOT SHALL last exactly one cycle after reset release, with NPC=RESET_PC, pcWrite=1, ifidFlush=1, idexFlush=1, and then go to RUN.
REQ-007 In RUN, target priority SHALL be cond > jmp > sequential: NPC = condNPC if cond, else jmpPC if jmp, else seqPC.
REQ-008 cond=1 SHALL assert ifidFlush=1 and idexFlush=1 in the same cycle (2-slot squash).
REQ-009 jmp=1 without cond SHALL assert ifidFlush=1 and idexFlush=0 (1-slot squash).
REQ-010 loadUse=1 without cond SHALL give pcWrite=0, ifidWrite=0 and idexFlush=1, and SHALL override jmp, so the jump is re-decoded after the stall.
REQ-011 cond=1 together with loadUse=1 SHALL favour cond: pcWrite=1, both flushes asserted, loadUse ignored.
REQ-012 memBusy=1 in RUN SHALL give pcWrite=0 and ifidWrite=0, and SHALL move to WAIT.
REQ-013 A redirect (cond or jmp) arriving with memBusy=1 SHALL latch its target and a pending flag in that cycle; its flush outputs SHALL still assert that cycle.
REQ-014 In WAIT, pcWrite=0 and ifidWrite=0 while memBusy=1.
REQ-015 In WAIT, a new cond SHALL overwrite the pending target; a jmp SHALL NOT overwrite a pending cond target.
REQ-016 In WAIT with memBusy=0, NPC SHALL be the pending target if the pending flag is set (otherwise the RUN selection), pcWrite=1, ifidFlush=pending flag, the pending flag cleared, and the next state RUN.
REQ-017 In RUN with no hazard: pcWrite=1, ifidWrite=1, both flushes 0.
REQ-018 All control outputs SHALL be combinational from state, pending register and inputs (0-cycle latency); state, pending and stallCnt SHALL be registered.
REQ-019 stallCnt SHALL increment by 1 on every cycle with pcWrite=0 outside BOOT, and SHALL saturate at 16'hFFFF (no wrap).
REQ-020 Targets SHALL be passed through unmodified at 32 bits, with no alignment check.

Reset
REQ-021 While rst=1: state=BOOT, pending flag=0, pending target=RESET_PC, stallCnt=0, NPC=RESET_PC, pcWrite=0, ifidWrite=0, ifidFlush=1, idexFlush=1.
REQ-022 Reset asserted mid-WAIT SHALL discard the pending redirect immediately.

Structure
REQ-023 State encodings, RESET_PC and BUBBLE SHALL be defined in a shared pipeline constants package used by the IF, ID and EX stages.
REQ-024 The block SHALL be a single module with no sub-modules; the saturating stall counter MAY be a sub-module named sat_counter.

Verification
REQ-025 Reset release, no hazards, seqPC=4: cycle 1 is BOOT with NPC=0; cycle 2 is RUN with NPC=4, pcWrite=1.
REQ-026 RUN, cond=1, condNPC=32'h40, jmp=1, jmpPC=32'h80: NPC=32'h40, ifidFlush=1, idexFlush=1.
REQ-027 loadUse=1 for 2 cycles with jmp=1: pcWrite=0 and idexFlush=1 for both cycles, stallCnt=2 afterwards, jmp not taken during the stall.
REQ-028 memBusy=1 for 3 cycles with cond=1, condNPC=32'h100 in cycle 1:
- state=WAIT for 3 cycles;
- on the first ready cycle NPC=32'h100, ifidFlush=1;
- then RUN.
REQ-029 WAIT with a pending cond to 32'h100, then jmp to 32'h200: the pending target stays 32'h100; a later cond to 32'h300 replaces it and NPC=32'h300 on release.
REQ-030 Force stallCnt to 16'hFFFE, hold memBusy=1 for 4 cycles: stallCnt reaches 16'hFFFF and holds; rst pulsed mid-WAIT gives state=BOOT, stallCnt=0, pending cleared.
